// File: rtl/stream_credit_receiver.sv
// stream_credit_receiver
// Receiving end of a credit-based stream link. Arriving beats are always
// accepted into a Depth-entry FIFO, presented downstream as valid/ready,
// and each beat consumed returns one registered credit pulse to the sender.
// Optional macro STREAM_CREDIT_RECEIVER_FALL_THROUGH_EN: when defined, a
// beat arriving at an empty FIFO is presented combinationally (latency 0)
// and is not stored if consumed in the same cycle.
module stream_credit_receiver #(
  parameter int DataWidth = 32,
  parameter int Depth     = 4,
  parameter int CntWidth  = $clog2(Depth + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 valid_i,
  input  logic [DataWidth-1:0] data_i,
  output logic                 credit_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [DataWidth-1:0] data_o,
  output logic [CntWidth-1:0]  usage_o,
  output logic                 overflow_o
);

  localparam int PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [DataWidth-1:0] mem_q [Depth];
  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntWidth-1:0]  usage_q, usage_d;
  logic                 credit_q, credit_d;
  logic                 overflow_q, overflow_d;

  logic empty, full, bypass, pop, rd_en, wr_en;

  // Depth need not be a power of two, so wrap by compare rather than truncation.
  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (usage_q == '0);
  assign full  = (usage_q == CntWidth'(Depth));

  // Downstream presentation: FIFO head, or the live link beat when fall-through applies.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no latch is inferred.
    valid_o = !empty;
    data_o  = mem_q[rd_ptr_q];
    bypass  = 1'b0;
`ifdef STREAM_CREDIT_RECEIVER_FALL_THROUGH_EN
    if (empty && valid_i) begin
      valid_o = 1'b1;
      data_o  = data_i;
      bypass  = ready_i;
    end
`endif
  end

  // A pop is any consumed beat (stored or bypassed); only stored beats advance rd_ptr.
  assign pop   = valid_o && ready_i;
  assign rd_en = pop && !empty;
  // When full, a same-cycle pop frees the slot this push uses.
  assign wr_en = valid_i && !bypass && (!full || rd_en);

  // Next-state for pointers, occupancy, credit return and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    usage_d    = usage_q;
    credit_d   = pop;
    overflow_d = overflow_q;
    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (rd_en) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (wr_en && !rd_en)      usage_d = usage_q + 1'b1;
    else if (!wr_en && rd_en) usage_d = usage_q - 1'b1;
    // Beat arriving with no free entry and no pop is dropped and flagged.
    if (valid_i && full && !rd_en) overflow_d = 1'b1;
    // Clear discards contents and suppresses any credit from a pop this cycle.
    if (clr_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      usage_d    = '0;
      credit_d   = 1'b0;
      overflow_d = 1'b0;
    end
  end

  // Control state register with synchronous reset taking priority over clear.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      usage_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      usage_q    <= usage_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage write.
  always_ff @(posedge clk_i) begin
    // NOTE: storage is deliberately not reset; usage_q alone decides which entries are valid.
    if (wr_en) mem_q[wr_ptr_q] <= data_i;
  end

  assign usage_o    = usage_q;
  assign credit_o   = credit_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_stream_credit_receiver.sv
// Self-checking bench for stream_credit_receiver. Two instances (Depth 4 and
// Depth 3) share one stimulus stream; each has its own scoreboard queue
// modelling the buffer contents, driven by the credit-link rules.
module tb_stream_credit_receiver;

  logic        clk;
  logic        rst;
  logic        clr;
  logic        valid_in;
  logic [31:0] data_in;
  logic        ready_in;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int depth,
                       input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (Depth=%0d): got 0x%0h, expected 0x%0h", name, depth, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int D  = (g == 0) ? 4 : 3;
    localparam int CW = $clog2(D + 1);

    logic          credit_o, valid_o, overflow_o;
    logic [31:0]   data_o;
    logic [CW-1:0] usage_o;

    stream_credit_receiver #(.DataWidth(32), .Depth(D)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .clr_i      (clr),
      .valid_i    (valid_in),
      .data_i     (data_in),
      .credit_o   (credit_o),
      .valid_o    (valid_o),
      .ready_i    (ready_in),
      .data_o     (data_o),
      .usage_o    (usage_o),
      .overflow_o (overflow_o)
    );

    // Scoreboard: beats accepted and not yet consumed, oldest first.
    logic [31:0] sb[$];
    bit          live       = 0;
    bit          ovf        = 0;
    bit          exp_credit = 0;
    bit          popped     = 0;
    bit          bypassed   = 0;
    bit          exp_valid;

    // Monitor: compare outputs mid-cycle and retire the head on a downstream handshake.
    always @(negedge clk) begin
      if (live) begin
        exp_valid = (sb.size() != 0);
`ifdef STREAM_CREDIT_RECEIVER_FALL_THROUGH_EN
        if (sb.size() == 0 && valid_in) exp_valid = 1'b1;
`endif
        check("valid_o", D, valid_o, exp_valid);
        check("usage_o", D, usage_o, sb.size());
        check("overflow_o", D, overflow_o, ovf);
        check("credit_o", D, credit_o, exp_credit);
        if (sb.size() != 0) check("data_o", D, data_o, sb[0]);
`ifdef STREAM_CREDIT_RECEIVER_FALL_THROUGH_EN
        else if (valid_in) check("data_o_fallthrough", D, data_o, data_in);
`endif
        if (valid_o && ready_in) begin
          if (sb.size() != 0) begin
            void'(sb.pop_front());
            popped = 1;
          end
`ifdef STREAM_CREDIT_RECEIVER_FALL_THROUGH_EN
          else if (valid_in) begin
            popped   = 1;
            bypassed = 1;
          end
`endif
          else check("pop_while_empty", D, valid_o, 1'b0);
        end
      end
    end

    // Reference model: apply the clock edge using the link rules.
    always @(posedge clk) begin
      if (rst) begin
        live       = 1;
        sb.delete();
        ovf        = 0;
        exp_credit = 0;
      end else if (live) begin
        if (clr) begin
          sb.delete();
          ovf        = 0;
          exp_credit = 0;
        end else begin
          exp_credit = popped;
          if (valid_in && !bypassed) begin
            // Any pop this cycle has already been retired, so room is simply size < D.
            if (sb.size() < D) sb.push_back(data_in);
            else ovf = 1;
          end
        end
      end
      popped   = 0;
      bypassed = 0;
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic r,
                       input logic c = 1'b0);
    valid_in = v;
    data_in  = d;
    ready_in = r;
    clr      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, r);
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; valid_in = 1'b0; data_in = '0; ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2, 1'b0);

    // Single beat through an idle link.
    drive(1'b1, 32'hA5A5_0001, 1'b1);
    idle(3, 1'b1);

    // Fill with downstream stalled, then drain back to back.
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i), 1'b0);
    idle(2, 1'b0);
    idle(5, 1'b1);

    // Full with simultaneous push and pop.
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i), 1'b0);
    drive(1'b1, 32'd5, 1'b1);
    idle(5, 1'b1);

    // Overflow while stalled, drain, then clear.
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'(i), 1'b0);
    drive(1'b1, 32'd9, 1'b0);
    idle(2, 1'b0);
    idle(5, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    idle(2, 1'b0);

    // Continuous streaming wraps the pointers several times.
    for (int i = 0; i < 10; i++) drive(1'b1, 32'(100 + i), 1'b1);
    idle(4, 1'b1);

    // Clear with a pop and a push in the same cycle.
    for (int i = 1; i <= 2; i++) drive(1'b1, 32'(20 + i), 1'b0);
    drive(1'b1, 32'd30, 1'b1, 1'b1);
    idle(3, 1'b1);

    // Reset in the middle of traffic.
    for (int i = 1; i <= 3; i++) drive(1'b1, 32'(40 + i), 1'b0);
    rst = 1'b1;
    drive(1'b1, 32'd50, 1'b1);
    rst = 1'b0;
    idle(3, 1'b1);

    // Randomised traffic with occasional clears.
    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 99) < 50, $urandom(), $urandom_range(0, 99) < 55,
            $urandom_range(0, 199) == 0);
    end
    idle(8, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
